// File: rtl/act_requant_pipe.sv
// Streaming multi-lane activation and requantisation stage: activation (S1), scale multiply (S2),
// round/saturate into the output register (S3), with full valid/ready backpressure.
module act_requant_pipe #(
   parameter int LANES  = 4,
   parameter int IN_W   = 32,
   parameter int OUT_W  = 8,
   parameter int MULT_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             cfg_mode,
   input  logic [4:0]             cfg_sh_a,
   input  logic [4:0]             cfg_sh_b,
   input  logic [MULT_W-1:0]      cfg_mult,
   input  logic [5:0]             cfg_rshift,
   input  logic                   sat_clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       out_sat,
   output logic                   busy,
   output logic [CNT_W-1:0]       sat_cnt
);

   localparam int PROD_W = IN_W + MULT_W + 1;
   localparam int RND_W  = PROD_W + 1;

   logic                     s1_valid_reg;
   logic                     s2_valid_reg;
   logic                     out_valid_reg;
   logic                     s1_load;
   logic                     s2_load;
   logic                     out_load;
   logic signed [IN_W-1:0]   s1_act_reg [LANES];
   logic signed [IN_W-1:0]   act_next [LANES];
   logic [PROD_W-1:0]        s2_prod_reg [LANES];
   logic [PROD_W-1:0]        prod_next [LANES];
   logic [LANES*OUT_W-1:0]   out_data_reg;
   logic [LANES*OUT_W-1:0]   out_data_next;
   logic [LANES-1:0]         out_sat_reg;
   logic [LANES-1:0]         out_sat_next;
   logic [CNT_W-1:0]         sat_cnt_reg;
   logic [CNT_W-1:0]         sat_cnt_next;
   logic [CNT_W:0]           pop_acc [LANES+1];
   logic [CNT_W:0]           sat_sum;

   function automatic logic signed [IN_W-1:0] activate(
      input logic signed [IN_W-1:0] x,
      input logic [1:0]             mode,
      input logic [4:0]             sh_a,
      input logic [4:0]             sh_b
   );
      logic signed [IN_W-1:0] term_b;
      term_b = '0;
      if (sh_b != 5'd0)
         term_b = x >>> sh_b;
      activate = x;
      if (x[IN_W-1]) begin
         case (mode)
            2'd1:    activate = '0;
            2'd2:    activate = (x >>> 3) - (x >>> 5);
            2'd3:    activate = (x >>> sh_a) - term_b;
            default: activate = x;
         endcase
      end
   endfunction

   // Returns {saturated, value}; rounding adds half an LSB before the arithmetic shift.
   function automatic logic [OUT_W:0] requant(
      input logic [PROD_W-1:0] prod,
      input logic [5:0]        rshift
   );
      logic [RND_W-1:0]        wide;
      logic [RND_W-1:0]        half;
      logic signed [RND_W-1:0] r;
      logic signed [RND_W-1:0] lim_hi;
      logic signed [RND_W-1:0] lim_lo;
      wide   = {prod[PROD_W-1], prod};
      half   = '0;
      lim_hi = RND_W'((1 << (OUT_W-1)) - 1);
      lim_lo = ~lim_hi;
      if (rshift != 6'd0) begin
         half = RND_W'(1) << (rshift - 6'd1);
         r    = $signed(wide + half) >>> rshift;
      end else begin
         r = $signed(wide);
      end
      if (r > lim_hi)
         requant = {1'b1, lim_hi[OUT_W-1:0]};
      else if (r < lim_lo)
         requant = {1'b1, lim_lo[OUT_W-1:0]};
      else
         requant = {1'b0, r[OUT_W-1:0]};
   endfunction

   // A stage loads when empty or when its current beat moves on in the same cycle.
   assign out_load = !out_valid_reg || out_ready;
   assign s2_load  = !s2_valid_reg || out_load;
   assign s1_load  = !s1_valid_reg || s2_load;
   assign in_ready = s1_load;

   assign pop_acc[0] = '0;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [PROD_W-1:0] act_ext;
         logic [PROD_W-1:0] mult_ext;

         assign act_next[gi] = activate($signed(in_data[gi*IN_W +: IN_W]),
                                        cfg_mode, cfg_sh_a, cfg_sh_b);
         // Scale is unsigned, so zero-extend it; the low PROD_W bits of the product are exact.
         assign act_ext       = {{(MULT_W+1){s1_act_reg[gi][IN_W-1]}}, s1_act_reg[gi]};
         assign mult_ext      = {{(IN_W+1){1'b0}}, cfg_mult};
         assign prod_next[gi] = act_ext * mult_ext;

         assign {out_sat_next[gi], out_data_next[gi*OUT_W +: OUT_W]} =
            requant(s2_prod_reg[gi], cfg_rshift);

         assign pop_acc[gi+1] = pop_acc[gi] + (CNT_W+1)'(out_sat_reg[gi]);
      end
   endgenerate

   assign sat_sum = {1'b0, sat_cnt_reg} + pop_acc[LANES];

   always_comb begin
      sat_cnt_next = sat_cnt_reg;
      if (sat_clr)
         sat_cnt_next = '0;
      else if (out_valid_reg && out_ready)
         sat_cnt_next = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sat_reg   <= '0;
         sat_cnt_reg   <= '0;
      end else begin
         if (s1_load)
            s1_valid_reg <= in_valid;
         if (s2_load)
            s2_valid_reg <= s1_valid_reg;
         if (out_load)
            out_valid_reg <= s2_valid_reg;
         if (out_load && s2_valid_reg) begin
            out_data_reg <= out_data_next;
            out_sat_reg  <= out_sat_next;
         end
         sat_cnt_reg <= sat_cnt_next;
      end
   end

   // Datapath registers carry no reset; their contents only matter alongside a set valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (s1_load && in_valid)
            s1_act_reg[i] <= act_next[i];
         if (s2_load && s1_valid_reg)
            s2_prod_reg[i] <= prod_next[i];
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;
   assign sat_cnt   = sat_cnt_reg;
   assign busy      = s1_valid_reg || s2_valid_reg || out_valid_reg;

endmodule
